// File: rtl/mem_stage_cached.sv
// rtl/mem_stage_cached.sv - MIPS MEM stage with direct-mapped write-through read-allocate data cache
// Misses and stores go to RAM over a req/ack handshake while oStall freezes the pipeline.
module mem_stage_cached #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         iSig_MemRead,
  input  logic                         iSig_MemWrite,
  input  logic                         iSig_branch,
  input  logic                         iALUzero,
  input  logic [ADDR_W-1:0]            iALUresult,
  input  logic [DATA_W-1:0]            iregfile_read_data2,
  output logic [DATA_W-1:0]            oMemReadData,
  output logic [ADDR_W-1:0]            oALUresult,
  output logic                         oSig_PCSrc,
  output logic                         ocacheHit,
  output logic                         oStall,
  output logic                         oram_req,
  output logic                         oram_we,
  output logic [ADDR_W-1:0]            oram_addr,
  output logic [DATA_W-1:0]            oram_wdata,
  input  logic                         iram_ack,
  input  logic [DATA_W*LINE_WORDS-1:0] iram_rdata
);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int OFF_W  = BYTE_W + $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WS_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [WS_W-1:0]   WS_MASK   = WS_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << BYTE_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;
  state_t state, state_nxt;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] lines [LINES][LINE_WORDS];

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              wr_hit;
  logic              done;

  logic [TAG_W-1:0] cur_tag, req_tag;
  logic [IDX_W-1:0] cur_idx, req_idx;
  logic [WS_W-1:0]  cur_word, req_word;

  assign cur_tag  = iALUresult[ADDR_W-1 -: TAG_W];
  assign cur_idx  = iALUresult[OFF_W +: IDX_W];
  assign cur_word = WS_W'(iALUresult >> BYTE_W) & WS_MASK;
  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_word = WS_W'(req_addr >> BYTE_W) & WS_MASK;

  assign ocacheHit    = valid[cur_idx] && (tags[cur_idx] == cur_tag);
  assign oMemReadData = lines[cur_idx][cur_word];
  assign oSig_PCSrc   = iSig_branch & iALUzero;

  assign oram_req   = (state != S_IDLE);
  assign oram_we    = (state == S_WRITE);
  assign oram_addr  = (state == S_WRITE) ? (req_addr & WORD_MASK) : (req_addr & LINE_MASK);
  assign oram_wdata = req_data;

  // 'done' marks the IDLE cycle right after an ack, so the still-presented
  // access is treated as finished instead of being started again.
  always_comb begin
    state_nxt = state;
    oStall    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!done) begin
          if (iSig_MemWrite) begin
            oStall    = 1'b1;
            state_nxt = S_WRITE;
          end else if (iSig_MemRead && !ocacheHit) begin
            oStall    = 1'b1;
            state_nxt = S_REFILL;
          end
        end
      end
      S_REFILL, S_WRITE: begin
        oStall = 1'b1;
        if (iram_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      valid      <= '0;
      done       <= 1'b0;
      oALUresult <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state != S_IDLE) && iram_ack;
      if (!oStall) oALUresult <= iALUresult;
      if (state == S_REFILL && iram_ack) valid[req_idx] <= 1'b1;
    end
  end

  // Request latch, tags and line data carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && state_nxt != S_IDLE) begin
      req_addr <= iALUresult;
      req_data <= iregfile_read_data2;
      wr_hit   <= ocacheHit;
    end
    if (rstn && state == S_REFILL && iram_ack) begin
      tags[req_idx] <= req_tag;
      for (int w = 0; w < LINE_WORDS; w++)
        lines[req_idx][WS_W'(w)] <= iram_rdata[w*DATA_W +: DATA_W];
    end
    if (rstn && state == S_WRITE && iram_ack && wr_hit)
      lines[req_idx][req_word] <= req_data;
  end
endmodule

// File: tb/tb_mem_stage_cached.sv
// tb/tb_mem_stage_cached.sv - self-checking bench for mem_stage_cached
// Reference model: word-addressed RAM plus per-index valid/tag of a direct-mapped cache.
module tb_mem_stage_cached;
  logic         clk = 1'b0;
  logic         rstn, rd, wr_s, br, zero, ack;
  logic [31:0]  alu, sdata;
  logic [127:0] rline;
  logic [31:0]  o_rdata, o_alu, o_ram_addr, o_ram_wdata;
  logic         o_pcsrc, o_hit, o_stall, o_req, o_we;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];
  logic        m_valid [16];
  logic [23:0] m_tag [16];

  always #5 clk = ~clk;

  mem_stage_cached dut (
    .clk(clk), .rstn(rstn),
    .iSig_MemRead(rd), .iSig_MemWrite(wr_s),
    .iSig_branch(br), .iALUzero(zero),
    .iALUresult(alu), .iregfile_read_data2(sdata),
    .oMemReadData(o_rdata), .oALUresult(o_alu),
    .oSig_PCSrc(o_pcsrc), .ocacheHit(o_hit), .oStall(o_stall),
    .oram_req(o_req), .oram_we(o_we), .oram_addr(o_ram_addr),
    .oram_wdata(o_ram_wdata), .iram_ack(ack), .iram_rdata(rline)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  // Presents one access, acts as the RAM (ack after 'waits' request cycles), checks timing and data.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int waits);
    bit exp_hit, fin;
    int exp_stalls, stalls, reqs;
    logic [31:0] wa, la;
    wa = addr & ~32'h3;
    la = addr & ~32'hF;
    exp_hit = m_valid[addr[7:4]] && (m_tag[addr[7:4]] == addr[31:8]);
    exp_stalls = (wr || !exp_hit) ? waits + 2 : 0;
    stalls = 0; reqs = 0; fin = 0;
    @(negedge clk);
    rd = !wr; wr_s = wr; alu = addr; sdata = wd;
    br = 1'($urandom); zero = 1'($urandom);
    #1;
    chk("hit_at_issue", o_hit, exp_hit);
    if (exp_hit && !wr) chk("no_req_on_hit", o_req, 1'b0);
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      chk("pcsrc", o_pcsrc, br & zero);
      if (!o_stall) fin = 1;
      else begin
        stalls++;
        if (o_req) begin
          chk("ram_we", o_we, wr);
          chk("ram_addr", o_ram_addr, wr ? wa : la);
          if (wr) chk("ram_wdata", o_ram_wdata, wd);
          if (reqs == waits) begin
            ack = 1'b1;
            rline = {rd_mem(la + 12), rd_mem(la + 8), rd_mem(la + 4), rd_mem(la)};
          end
          reqs++;
        end
        @(negedge clk);
        ack = 1'b0; br = 1'($urandom); zero = 1'($urandom);
        #1;
      end
    end
    chk("access_completes", fin, 1'b1);
    chk("stall_cycles", stalls, exp_stalls);
    chk("req_cycles", reqs, (exp_stalls == 0) ? 0 : waits + 1);
    if (!wr) begin
      chk("hit_after", o_hit, 1'b1);
      chk("read_data", o_rdata, rd_mem(wa));
      if (!exp_hit) begin
        m_valid[addr[7:4]] = 1'b1;
        m_tag[addr[7:4]]   = addr[31:8];
      end
    end else begin
      mem[wa] = wd;
    end
    @(negedge clk);
    rd = 1'b0; wr_s = 1'b0;
    #1;
    chk("alu_out", o_alu, addr);
  endtask

  initial begin
    logic [31:0] a;
    clear_model();
    rstn = 1'b0; rd = 1'b1; wr_s = 1'b0; br = 1'b1; zero = 1'b1;
    alu = 32'h40; sdata = '0; ack = 1'b0; rline = '0;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_req", o_req, 1'b0);
      chk("rst_we", o_we, 1'b0);
      chk("rst_hit", o_hit, 1'b0);
      chk("rst_stall", o_stall, 1'b1);
      chk("rst_alu", o_alu, 32'h0);
      chk("rst_pcsrc", o_pcsrc, 1'b1);
    end
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("refill_req", o_req, 1'b1);
    chk("refill_addr", o_ram_addr, 32'h40);
    chk("refill_we", o_we, 1'b0);
    chk("alu_held", o_alu, 32'h0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("refill_req2", o_req, 1'b1);
    chk("pcsrc_stalled", o_pcsrc, 1'b1);
    @(negedge clk); #1;
    chk("abort_req", o_req, 1'b0);
    chk("abort_alu", o_alu, 32'h0);
    rstn = 1'b1; rd = 1'b0; br = 1'b0;

    mem[32'h40] = 32'hD0; mem[32'h44] = 32'hD1;
    mem[32'h48] = 32'hD2; mem[32'h4C] = 32'hD3;
    access(0, 32'h44, 0, 3);
    access(0, 32'h4C, 0, 0);
    access(1, 32'h48, 32'hCAFEBABE, 0);
    access(0, 32'h48, 0, 0);
    access(1, 32'h400, 32'h1234, 0);
    access(0, 32'h400, 0, 1);
    access(0, 32'h40, 0, 0);
    access(0, 32'h440, 0, 2);
    access(0, 32'h40, 0, 0);

    for (int n = 0; n < 40; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      access(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    rd = 1'b1; alu = 32'h8000;
    @(negedge clk); #1;
    chk("r2_req", o_req, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk); #1;
    chk("r2_abort_req", o_req, 1'b0);
    chk("r2_hit_cleared", o_hit, 1'b0);
    rstn = 1'b1; rd = 1'b0;
    clear_model();
    access(0, 32'h44, 0, 1);
    access(0, 32'h8000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
